input_conditioner: RTL and testbench
====================================

# input_conditioner

Synchronises and debounces a single asynchronous input line (switch or external strobe) and delivers a clean level plus one-cycle edge pulses to the downstream sequence-detect FSM, whose `in` input is driven by `in_level`. The block uses a multi-flop synchroniser followed by a four-state debounce FSM with a stability counter. An optional saturating counter records rejected glitches for debug.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth; legal range 2..4.
- `DEBOUNCE_CYCLES`, default 16: number of consecutive synchronised samples of a new value required before commit; legal range 2..255.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `raw_in`  in  1  asynchronous raw input; no timing relationship to `clk`.
- `in_level`  out  1  debounced level; feeds the downstream FSM `in`.
- `in_rise`  out  1  one-cycle pulse on committed 0->1 of `in_level`.
- `in_fall`  out  1  one-cycle pulse on committed 1->0 of `in_level`.
- `cond_state`  out  2  debounce FSM state, for debug.
- `glitch_cnt`  out  8  rejected-glitch count, saturating.

## Operation
- Synchroniser: `SYNC_STAGES` flops in series; `sync` is the last stage. All stages reset to 0.
- FSM states and encodings: STABLE_LO=00, PEND_HI=01, STABLE_HI=10, PEND_LO=11.
- STABLE_LO:
  - `sync`=1 -> PEND_HI, cnt=1.
  - Otherwise hold, cnt=0.
- PEND_HI:
  - `sync`=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, cnt=0, `in_level`<=1, `in_rise`<=1.
  - `sync`=1, cnt below that -> stay, cnt+1.
  - `sync`=0 -> STABLE_LO, cnt=0, glitch event.
- STABLE_HI and PEND_LO: mirror images of the above. Commit drives `in_level`<=0 and `in_fall`<=1.
- Glitch event: `glitch_cnt` increments by 1 and saturates at 8'hFF; it never wraps.
- cnt width: ceil(log2(DEBOUNCE_CYCLES+1)) bits. cnt never exceeds DEBOUNCE_CYCLES-1.
- `in_rise`/`in_fall` are registered and high for exactly one cycle per commit. They are never high simultaneously.
- `cond_state` reflects the registered state directly.

## Timing
- Reset values: `in_level`=0, `in_rise`=0, `in_fall`=0, `cond_state`=00, `glitch_cnt`=0, cnt=0, all sync flops=0.
- `rst` clears every flop immediately, including mid-PEND. Any pending transition is discarded and is not counted as a glitch.
- Latency: let edge E1 be the first clk edge that samples a new `raw_in` value. If `raw_in` stays stable from E1 on, `in_level` and the edge pulse update at edge E(SYNC_STAGES+DEBOUNCE_CYCLES). With defaults that is E18.
- Minimum accepted pulse width: DEBOUNCE_CYCLES clk periods of the synchronised signal. Anything shorter is rejected and counted as a glitch.
- `raw_in` high during/at reset release: the block debounces from STABLE_LO and produces `in_rise`. This is required behaviour; downstream sees a clean edge.
- `sync` toggling every cycle while in a PEND state: each return to the committed value is one glitch event. `in_level` never changes.
- The FSM consumes one `sync` sample per cycle. There is no back-pressure.

## Configuration
- `INPUT_COND_GLITCH_CNT_EN`:
  - Defined: glitch counter implemented as described.
  - Undefined: no counter flops; `glitch_cnt` tied to 8'h00.
- Debounce behaviour and all other outputs are identical in both builds.

## Test plan
- Reset with `raw_in`=0, release, hold 40 cycles -> all outputs stay at reset values; `cond_state`=00 throughout.
- Defaults, `raw_in` 0->1 held stable -> `cond_state`=01 at E3; `in_level`=1 and `in_rise`=1 for one cycle at E18; `cond_state`=10 at E18.
- Defaults, `raw_in` high for 10 cycles then low -> `in_level` stays 0, no pulses, `glitch_cnt`=1 (0 without macro). Repeat 300 times -> `glitch_cnt`=8'hFF, no wrap.
- From STABLE_HI, `raw_in`->0 held -> `in_fall` single pulse at E18, `in_level`=0, `in_rise` stays 0.
- `rst` asserted while `cond_state`=01 with cnt=9 -> all outputs return to reset values immediately, asynchronously. After release, `raw_in`=1 held -> commit at E18 counted from the first post-reset sampling edge; `glitch_cnt` stays 0.
- DEBOUNCE_CYCLES=2, SYNC_STAGES=3 -> stable change commits at E5; a 1-cycle `raw_in` pulse is rejected and counted.

Source files
------------

// File: rtl/input_conditioner.sv
// ============================================================================
// input_conditioner
// ----------------------------------------------------------------------------
// Synchronises and debounces one asynchronous input line. It produces a clean
// level plus one-cycle rise/fall pulses. in_level drives the `in` input of the
// downstream sequence-detect FSM.
//
// Structure:
//   raw_in -> SYNC_STAGES flop chain -> sync -> 4-state debounce FSM
//   A new level is committed only after DEBOUNCE_CYCLES consecutive sync
//   samples of that value. A shorter excursion is dropped and counts as one
//   glitch.
//
// Parameters:
//   SYNC_STAGES      synchroniser depth (2..4)
//   DEBOUNCE_CYCLES  consecutive samples needed to commit (2..255)
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   raw_in      asynchronous raw input
//   in_level    debounced level
//   in_rise     one-cycle pulse on a committed 0->1
//   in_fall     one-cycle pulse on a committed 1->0
//   cond_state  debounce FSM state (debug)
//   glitch_cnt  saturating rejected-glitch count (debug)
//
// Build option:
//   INPUT_COND_GLITCH_CNT_EN  when defined, implements the glitch counter.
//                             When undefined, glitch_cnt is tied to 0.
// ============================================================================
module input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_in,
    output logic       in_level,
    output logic       in_rise,
    output logic       in_fall,
    output logic [1:0] cond_state,
    output logic [7:0] glitch_cnt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        PEND_HI   = 2'b01,
        STABLE_HI = 2'b10,
        PEND_LO   = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser: shift chain, last stage is the only one used.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_ff <= '0;
        else     sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw_in};
    end

    assign sync = sync_ff[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce FSM. cnt holds how many consecutive new-value samples have
    // been seen. Commit happens on the sample that would make it
    // DEBOUNCE_CYCLES, so cnt itself tops out at DEBOUNCE_CYCLES-1.
    // ------------------------------------------------------------------
    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= STABLE_LO;
            cnt      <= '0;
            in_level <= 1'b0;
            in_rise  <= 1'b0;
            in_fall  <= 1'b0;
        end else begin
            in_rise <= 1'b0;
            in_fall <= 1'b0;
            case (state)
                STABLE_LO: begin
                    if (sync) begin
                        state <= PEND_HI;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                PEND_HI: begin
                    if (!sync) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= STABLE_HI;
                        cnt      <= '0;
                        in_level <= 1'b1;
                        in_rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STABLE_HI: begin
                    if (!sync) begin
                        state <= PEND_LO;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                PEND_LO: begin
                    if (sync) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= STABLE_LO;
                        cnt      <= '0;
                        in_level <= 1'b0;
                        in_fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign cond_state = state;

    // ------------------------------------------------------------------
    // Glitch counter: a pending state falling back to its committed value.
    // ------------------------------------------------------------------
`ifdef INPUT_COND_GLITCH_CNT_EN
    logic       glitch;
    logic [7:0] gcnt;

    assign glitch = ((state == PEND_HI) && !sync) || ((state == PEND_LO) && sync);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          gcnt <= 8'h00;
        else if (glitch && gcnt != 8'hFF) gcnt <= gcnt + 8'h01;
    end

    assign glitch_cnt = gcnt;
`else
    assign glitch_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboarded bench for input_conditioner. Two instances run from the same
// raw_in: the defaults (2/16) and a short one (3/2). The reference model treats
// the synchroniser as a pure N-sample delay. It treats debounce as a run-length
// rule: N consecutive samples differing from the level flip it, and a run that
// breaks early counts as one glitch.
module tb_input_conditioner;

    localparam int S0 = 2, D0 = 16;
    localparam int S1 = 3, D1 = 2;
`ifdef INPUT_COND_GLITCH_CNT_EN
    localparam bit GC_EN = 1'b1;
`else
    localparam bit GC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       raw_in = 1'b0;
    logic       lvl0, rise0, fall0, lvl1, rise1, fall1;
    logic [1:0] st0, st1;
    logic [7:0] gc0, gc1;

    input_conditioner #(.SYNC_STAGES(S0), .DEBOUNCE_CYCLES(D0)) dut0 (
        .clk(clk), .rst(rst), .raw_in(raw_in), .in_level(lvl0), .in_rise(rise0),
        .in_fall(fall0), .cond_state(st0), .glitch_cnt(gc0));

    input_conditioner #(.SYNC_STAGES(S1), .DEBOUNCE_CYCLES(D1)) dut1 (
        .clk(clk), .rst(rst), .raw_in(raw_in), .in_level(lvl1), .in_rise(rise1),
        .in_fall(fall1), .cond_state(st1), .glitch_cnt(gc1));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       lvl;
        logic       rise;
        logic       fall;
        logic [1:0] st;
        logic [7:0] gc;
    } obs_t;

    typedef struct {
        bit level;
        int run;
        int glitch;
    } mst_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   rise_cyc0, rise_cyc1, fall_cyc0, fall_cyc1;
    obs_t q0[$], q1[$];
    bit   h0[$], h1[$];
    mst_t m0, m1;

    // ---------------- reference model ----------------
    function automatic obs_t mstep(input int d, input bit s, inout mst_t m);
        obs_t o;
        o = '0;
        if (s != m.level) begin
            m.run++;
            if (m.run == d) begin
                m.level = s;
                o.rise  = s;
                o.fall  = !s;
                m.run   = 0;
            end
        end else begin
            if (m.run > 0) m.glitch++;
            m.run = 0;
        end
        o.lvl = m.level;
        o.st  = {m.level, (m.run > 0)};
        o.gc  = GC_EN ? ((m.glitch > 255) ? 8'hFF : 8'(m.glitch)) : 8'h00;
        return o;
    endfunction

    task automatic model_reset();
        m0 = '{0, 0, 0};
        m1 = '{0, 0, 0};
        h0 = {};
        h1 = {};
        for (int i = 0; i < S0; i++) h0.push_back(1'b0);
        for (int i = 0; i < S1; i++) h1.push_back(1'b0);
        q0 = {};
        q1 = {};
    endtask

    // Drive raw_in for the coming posedge, queue the expected response, and
    // advance to the next negedge.
    task automatic tick(input bit r);
        bit s;
        raw_in = r;
        h0.push_back(r); s = h0.pop_front(); q0.push_back(mstep(D0, s, m0));
        h1.push_back(r); s = h1.pop_front(); q1.push_back(mstep(D1, s, m1));
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called just after a negedge. The pulse stays inside the low phase, so
    // the clear must come from the asynchronous path.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk("async_rst dut0", int'({lvl0, rise0, fall0, st0, gc0}), 0);
        chk("async_rst dut1", int'({lvl1, rise1, fall1, st1, gc1}), 0);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        obs_t e, a;
        #1;
        cyc++;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a = {lvl0, rise0, fall0, st0, gc0};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL dut0 cyc %0d: got lvl%b r%b f%b st%b gc%h expected lvl%b r%b f%b st%b gc%h",
                         cyc, a.lvl, a.rise, a.fall, a.st, a.gc, e.lvl, e.rise, e.fall, e.st, e.gc);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a = {lvl1, rise1, fall1, st1, gc1};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL dut1 cyc %0d: got lvl%b r%b f%b st%b gc%h expected lvl%b r%b f%b st%b gc%h",
                         cyc, a.lvl, a.rise, a.fall, a.st, a.gc, e.lvl, e.rise, e.fall, e.st, e.gc);
            end
        end
        if (rise0 === 1'b1) rise_cyc0 = cyc;
        if (rise1 === 1'b1) rise_cyc1 = cyc;
        if (fall0 === 1'b1) fall_cyc0 = cyc;
        if (fall1 === 1'b1) fall_cyc1 = cyc;
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0, len;
        bit v;
        model_reset();
        @(negedge clk);
        do_reset();

        // Idle low: everything stays at reset values.
        for (int i = 0; i < 40; i++) tick(1'b0);

        // Rise latency, counted from E1.
        c0 = cyc; rise_cyc0 = -1; rise_cyc1 = -1;
        tick(1'b1);
        tick(1'b1);
        chk("pend_hi at E2", int'(st0), 0);
        tick(1'b1);
        chk("pend_hi at E3", int'(st0), 1);
        for (int i = 0; i < 27; i++) tick(1'b1);
        chk("rise latency dut0", rise_cyc0 - c0, S0 + D0);
        chk("rise latency dut1", rise_cyc1 - c0, S1 + D1);

        // Fall latency.
        c0 = cyc; fall_cyc0 = -1; fall_cyc1 = -1; rise_cyc0 = -1;
        for (int i = 0; i < 30; i++) tick(1'b0);
        chk("fall latency dut0", fall_cyc0 - c0, S0 + D0);
        chk("fall latency dut1", fall_cyc1 - c0, S1 + D1);
        chk("no rise on fall dut0", rise_cyc0, -1);

        // Short pulses on dut0: 1 glitch, then saturation after 300.
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b1);
        for (int i = 0; i < 20; i++) tick(1'b0);
        chk("glitch once dut0", int'(gc0), GC_EN ? 1 : 0);
        chk("level after glitch dut0", int'(lvl0), 0);
        for (int p = 0; p < 299; p++) begin
            for (int i = 0; i < 10; i++) tick(1'b1);
            for (int i = 0; i < 20; i++) tick(1'b0);
        end
        chk("glitch saturate dut0", int'(gc0), GC_EN ? 255 : 0);

        // One-cycle pulse is rejected by the short instance too.
        do_reset();
        tick(1'b1);
        for (int i = 0; i < 10; i++) tick(1'b0);
        chk("1cyc pulse glitch dut1", int'(gc1), GC_EN ? 1 : 0);
        chk("1cyc pulse level dut1", int'(lvl1), 0);

        // Reset mid-pend (cnt=9 at E11), then debounce again with raw_in high.
        for (int i = 0; i < 11; i++) tick(1'b1);
        chk("mid pend state", int'(st0), 1);
        do_reset();
        c0 = cyc; rise_cyc0 = -1;
        for (int i = 0; i < 25; i++) tick(1'b1);
        chk("post-reset rise latency", rise_cyc0 - c0, S0 + D0);
        chk("post-reset glitch", int'(gc0), 0);

        // Random runs of assorted lengths around both debounce thresholds.
        for (int seg = 0; seg < 250; seg++) begin
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) tick(v);
        end
        for (int i = 0; i < 4; i++) tick(raw_in);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
